// File: rtl/dec_pkg.sv
// Shared state encoding, default sizes and entry layout for the one-hot decoder
// with skid buffer.
package dec_pkg;

  localparam int DEC_AW   = 5;
  localparam int DEC_NOUT = 32;
  localparam int DEC_CW   = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } dec_state_t;

  // Entry layout at the default sizes; the top rebuilds it at its own widths.
  typedef struct packed {
    logic [DEC_NOUT-1:0] onehot;
    logic [DEC_AW-1:0]   addr;
    logic                range_err;
  } dec_entry_t;

endpackage

// File: rtl/dec_onehot_comb.sv
// Combinational AW-to-NOUT one-hot decoder with enable gate and range flag.
// DEC_ONEHOT_ZERO_MASK_EN forces bit 0 low ($zero is never written).
module dec_onehot_comb
  import dec_pkg::*;
#(
  parameter int AW   = DEC_AW,
  parameter int NOUT = DEC_NOUT
) (
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [NOUT-1:0] onehot,
  output logic            range_err
);

  // One extra bit so NOUT == 2^AW is representable; the compare then folds to 0.
  localparam logic [AW:0] NOUT_W = (AW+1)'(NOUT);

  always_comb begin
    onehot    = '0;
    range_err = ({1'b0, addr} >= NOUT_W);
    for (int i = 0; i < NOUT; i++) begin
      onehot[i] = en & ({1'b0, addr} == (AW+1)'(i));
    end
`ifdef DEC_ONEHOT_ZERO_MASK_EN
    onehot[0] = 1'b0;
`else
    onehot[0] = en & ({1'b0, addr} == '0);
`endif
  end

endmodule

// File: rtl/dec_onehot_skid.sv
// Registered address-to-one-hot decoder with valid/ready on both sides and a
// 2-entry skid buffer. DEC_ONEHOT_ZERO_MASK_EN masks bit 0 in the decoder.
module dec_onehot_skid
  import dec_pkg::*;
#(
  parameter int AW   = DEC_AW,
  parameter int NOUT = DEC_NOUT,
  parameter int CW   = DEC_CW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_addr,
  input  logic            in_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NOUT-1:0] out_onehot,
  output logic [AW-1:0]   out_addr,
  output logic            out_range_err,
  output logic [CW-1:0]   xfer_count
);

  typedef struct packed {
    logic [NOUT-1:0] onehot;
    logic [AW-1:0]   addr;
    logic            range_err;
  } entry_t;

  dec_state_t      state_q, state_d;
  entry_t          main_q, main_d, skid_q, skid_d, new_entry;
  logic [NOUT-1:0] dec_onehot;
  logic            dec_err;
  logic            in_ready_q;
  logic            accept, xfer;
  logic [CW-1:0]   count_q;

  // Decode once at the input so both buffer entries hold finished vectors.
  dec_onehot_comb #(
    .AW   (AW),
    .NOUT (NOUT)
  ) u_dec (
    .addr      (in_addr),
    .en        (in_en),
    .onehot    (dec_onehot),
    .range_err (dec_err)
  );

  assign new_entry = {dec_onehot, in_addr, dec_err};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = in_valid & in_ready_q;
    xfer    = (state_q != EMPTY) & out_ready;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = FULL;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next state so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
      if (xfer) count_q <= count_q + CW'(1);
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != EMPTY);
  assign out_onehot    = main_q.onehot;
  assign out_addr      = main_q.addr;
  assign out_range_err = main_q.range_err;
  assign xfer_count    = count_q;

endmodule
